// File: rtl/rr_merge_node_nway_if.sv
// ============================================================================
// Module      : rr_merge_node_nway_if
// Description : Child-side and parent-side handshake bundle of the N-way merge node.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface rr_merge_node_nway_if #(
    parameter int N_IN      = 2,
    parameter int IN_HDR_W  = 8,
    parameter int IN_DATA_W = 512,
    parameter int CNT_W     = $clog2(N_IN + 1)
);
    logic [N_IN-1:0]           in_valid;
    logic [N_IN-1:0]           in_ready;
    logic [N_IN*IN_HDR_W-1:0]  in_hdr;
    logic [N_IN*IN_DATA_W-1:0] in_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_IN*IN_HDR_W-1:0]  out_hdr;
    logic [N_IN*IN_DATA_W-1:0] out_data;
    logic [CNT_W-1:0]          out_cnt;
    logic [31:0]               stat_pkts;
    logic [31:0]               stat_partial;

    modport master (
        output in_valid, in_hdr, in_data, flush, out_ready,
        input  in_ready, out_valid, out_hdr, out_data, out_cnt, stat_pkts, stat_partial
    );

    modport slave (
        input  in_valid, in_hdr, in_data, flush, out_ready,
        output in_ready, out_valid, out_hdr, out_data, out_cnt, stat_pkts, stat_partial
    );
endinterface

`default_nettype wire

// File: rtl/rr_merge_node_nway.sv
// ============================================================================
// Module      : rr_merge_node_nway
// Description : N-way gather/compact merge node with bounded wait window; N_IN=1 is a queue stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_merge_node_nway #(
    parameter int N_IN      = 2,
    parameter int IN_HDR_W  = 8,
    parameter int IN_DATA_W = 512,
    parameter int MAX_WAIT  = 0,
    parameter int CNT_W     = $clog2(N_IN + 1)
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    rr_merge_node_nway_if.slave bus
);
    localparam int               WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(N_IN);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_GATHER = 1'b1;

    logic [0:0]                state, state_nxt;
    logic [WAIT_W-1:0]         wait_cnt, wait_nxt, wait_inc;
    logic                      slot_free, any_v, all_v, cap;
    logic [N_IN-1:0]           ready_c;
    logic [N_IN*IN_HDR_W-1:0]  hdr_c;
    logic [N_IN*IN_DATA_W-1:0] data_c;
    logic [CNT_W-1:0]          cnt_c;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign any_v     = |bus.in_valid;
    assign all_v     = &bus.in_valid;
    assign wait_inc  = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + WAIT_W'(1);

    generate
        if (N_IN == 1) begin : g_queue
            logic unused_queue;
            assign cap          = slot_free && bus.in_valid[0];
            assign unused_queue = ^{bus.flush, all_v};
        end else begin : g_merge
            assign cap = slot_free && any_v && (all_v || bus.flush || (wait_cnt == WAIT_LIM));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // The window keeps counting (saturated) while a full slot blocks capture.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (any_v && !cap) begin
                    state_nxt = S_GATHER;
                    wait_nxt  = wait_inc;
                end
            end
            S_GATHER: begin
                if (cap) begin
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        ready_c = cap ? bus.in_valid : '0;
        hdr_c   = '0;
        data_c  = '0;
        cnt_c   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.in_valid[i]) begin
                hdr_c[i*IN_HDR_W +: IN_HDR_W]      = bus.in_hdr[i*IN_HDR_W +: IN_HDR_W];
                data_c[cnt_c*IN_DATA_W +: IN_DATA_W] = bus.in_data[i*IN_DATA_W +: IN_DATA_W];
                cnt_c                              = cnt_c + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = ready_c;

    // A capture during a drain simply overwrites the slot, giving back-to-back packets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_valid    <= 1'b0;
            bus.out_hdr      <= '0;
            bus.out_data     <= '0;
            bus.out_cnt      <= '0;
            bus.stat_pkts    <= '0;
            bus.stat_partial <= '0;
        end else if (cap) begin
            bus.out_valid <= 1'b1;
            bus.out_hdr   <= hdr_c;
            bus.out_data  <= data_c;
            bus.out_cnt   <= cnt_c;
            bus.stat_pkts <= bus.stat_pkts + 32'd1;
            if (cnt_c != FULL_CNT) begin
                bus.stat_partial <= bus.stat_partial + 32'd1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

`default_nettype wire
